// File: rtl/count_sweep_ctrl_if.sv
// Control/status bundle between register logic, sweep sequencer
// and the attached up/down counter.
interface count_sweep_ctrl_if #(
  parameter int SWEEPS_W = 8
);
  logic                start;
  logic                abort;
  logic [SWEEPS_W-1:0] num_sweeps;
  logic                cnt_tc;
  logic                cnt_en;
  logic                cnt_up_down;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [SWEEPS_W-1:0] sweep_cnt;
  logic [2:0]          phase;

  modport master (
    output start,
    output abort,
    output num_sweeps,
    output cnt_tc,
    input  cnt_en,
    input  cnt_up_down,
    input  busy,
    input  done,
    input  aborted,
    input  sweep_cnt,
    input  phase
  );

  modport slave (
    input  start,
    input  abort,
    input  num_sweeps,
    input  cnt_tc,
    output cnt_en,
    output cnt_up_down,
    output busy,
    output done,
    output aborted,
    output sweep_cnt,
    output phase
  );
endinterface

// File: rtl/count_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter with
// dwell at both extremes, sweep counting and abort-to-zero.
module count_sweep_ctrl #(
  parameter int END_COUNT = 16,
  parameter int DWELL     = 4,
  parameter int SWEEPS_W  = 8
) (
  input logic               clk,
  input logic               reset,
  count_sweep_ctrl_if.slave bus
);

  localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [DW-1:0] DW_LD =
    (DWELL > 0) ? DW'(DWELL - 1) : '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    DWELL_HI = 3'd2,
    DOWN     = 3'd3,
    DWELL_LO = 3'd4,
    RETURN   = 3'd5
  } state_t;

  state_t              state;
  state_t              nxt;
  logic [DW-1:0]       dwell;
  logic [SWEEPS_W-1:0] n_lat;
  logic [SWEEPS_W-1:0] sweep_cnt;
  logic [SWEEPS_W-1:0] sweep_inc;
  logic                sweep_end;
  logic                last;
  logic                busy;
  logic                done;
  logic                aborted;
  logic                up_down;
  logic                run_st;

  assign sweep_inc = sweep_cnt + 1'b1;
  assign last = (n_lat != '0) && (sweep_inc == n_lat);

  always_comb begin
    nxt       = state;
    sweep_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort && bus.cnt_tc)
          nxt = UP;
      end
      UP: begin
        if (bus.abort)
          nxt = RETURN;
        else if (bus.cnt_tc)
          nxt = (DWELL == 0) ? DOWN : DWELL_HI;
      end
      DWELL_HI: begin
        if (bus.abort)
          nxt = RETURN;
        else if (dwell == '0)
          nxt = DOWN;
      end
      DOWN: begin
        if (bus.abort)
          nxt = RETURN;
        else if (bus.cnt_tc) begin
          if (DWELL == 0)
            sweep_end = 1'b1;
          else
            nxt = DWELL_LO;
        end
      end
      DWELL_LO: begin
        if (bus.abort)
          nxt = RETURN;
        else if (dwell == '0)
          sweep_end = 1'b1;
      end
      RETURN: begin
        if (bus.cnt_tc)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (sweep_end)
      nxt = last ? IDLE : UP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      dwell     <= '0;
      n_lat     <= '0;
      sweep_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      up_down   <= 1'b0;
    end else begin
      state   <= nxt;
      busy    <= (nxt != IDLE);
      done    <= (state != IDLE) && (nxt == IDLE);
      up_down <= (nxt == UP) || (nxt == DWELL_HI);
      if (state == IDLE && nxt == UP) begin
        n_lat     <= bus.num_sweeps;
        sweep_cnt <= '0;
        aborted   <= 1'b0;
      end
      if (sweep_end)
        sweep_cnt <= sweep_inc;
      if (state == RETURN && nxt == IDLE)
        aborted <= 1'b1;
      // reload only on entry; held states just count down
      if (nxt != state &&
          (nxt == DWELL_HI || nxt == DWELL_LO))
        dwell <= DW_LD;
      else if (dwell != '0)
        dwell <= dwell - 1'b1;
    end
  end

  always_comb begin
    run_st = 1'b0;
    unique case (1'b1)
      state == UP,
      state == DOWN,
      state == RETURN: run_st = 1'b1;
      default:         run_st = 1'b0;
    endcase
  end

  assign bus.cnt_en      = run_st && !bus.cnt_tc;
  assign bus.cnt_up_down = up_down;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.aborted     = aborted;
  assign bus.sweep_cnt   = sweep_cnt;
  assign bus.phase       = state;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: timeline model of the sweep plus
// directed runs on a DWELL=4 and a DWELL=0 instance.
module tb_count_sweep_ctrl;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit armed  = 1'b0;

  logic       start_v [2] = '{1'b0, 1'b0};
  logic       abort_v [2] = '{1'b0, 1'b0};
  logic [7:0] ns_v    [2] = '{8'd0, 8'd0};

  count_sweep_ctrl_if #(.SWEEPS_W(8)) ifa ();
  count_sweep_ctrl_if #(.SWEEPS_W(8)) ifb ();

  count_sweep_ctrl #(.END_COUNT(N), .DWELL(4), .SWEEPS_W(8)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa.slave)
  );
  count_sweep_ctrl #(.END_COUNT(N), .DWELL(0), .SWEEPS_W(8)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb.slave)
  );

  int cnt_a = 0;
  int cnt_b = 0;
  logic tc_a, tc_b;

  assign tc_a = ifa.cnt_up_down ? (cnt_a == N-1) : (cnt_a == 0);
  assign tc_b = ifb.cnt_up_down ? (cnt_b == N-1) : (cnt_b == 0);

  assign ifa.start      = start_v[0];
  assign ifa.abort      = abort_v[0];
  assign ifa.num_sweeps = ns_v[0];
  assign ifa.cnt_tc     = tc_a;
  assign ifb.start      = start_v[1];
  assign ifb.abort      = abort_v[1];
  assign ifb.num_sweeps = ns_v[1];
  assign ifb.cnt_tc     = tc_b;

  // plain counters, no modulus, so any wrap shows up as a bad count
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      if (ifa.cnt_en === 1'b1)
        cnt_a <= ifa.cnt_up_down ? cnt_a + 1 : cnt_a - 1;
      if (ifb.cnt_en === 1'b1)
        cnt_b <= ifb.cnt_up_down ? cnt_b + 1 : cnt_b - 1;
    end
  end

  typedef enum {M_IDLE, M_RUN, M_RET} mode_t;
  int         dw  [2] = '{4, 0};
  mode_t      md  [2] = '{M_IDLE, M_IDLE};
  int         t   [2] = '{0, 0};
  int         rc  [2] = '{0, 0};
  int         k   [2] = '{0, 0};
  logic [7:0] swc [2] = '{8'd0, 8'd0};
  logic [7:0] nsl [2] = '{8'd0, 8'd0};
  bit         abt [2] = '{1'b0, 1'b0};
  bit         dn  [2] = '{1'b0, 1'b0};

  // phase and count at time tt edges after the start edge
  function automatic void exp_at(input int tt, input int d,
                                 output int ph, output int c);
    int p, r;
    p = 2*N + 2*d;
    r = tt % p;
    if (r < N) begin
      ph = 1; c = r;
    end else if (r < N + d) begin
      ph = 2; c = N - 1;
    end else if (r < 2*N + d) begin
      ph = 3; c = N - 1 - (r - N - d);
    end else begin
      ph = 4; c = 0;
    end
  endfunction

  task automatic mstep(input int u);
    int ph, c, p;
    p = 2*N + 2*dw[u];
    dn[u] = 1'b0;
    case (md[u])
      M_IDLE: if (start_v[u] && !abort_v[u]) begin
        md[u] = M_RUN; t[u] = 0; nsl[u] = ns_v[u];
        swc[u] = 8'd0; abt[u] = 1'b0;
      end
      M_RUN: if (abort_v[u]) begin
        exp_at(t[u] + 1, dw[u], ph, c);
        rc[u] = c; k[u] = 0; md[u] = M_RET;
      end else begin
        t[u]++;
        if (t[u] % p == 0) begin
          swc[u] = swc[u] + 8'd1;
          if (nsl[u] != 8'd0 && swc[u] == nsl[u]) begin
            md[u] = M_IDLE; dn[u] = 1'b1;
          end
        end
      end
      M_RET: begin
        k[u]++;
        if (k[u] == rc[u] + 1) begin
          md[u] = M_IDLE; dn[u] = 1'b1; abt[u] = 1'b1;
        end
      end
      default: md[u] = M_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (!rst) begin
        md[u] = M_IDLE; swc[u] = 8'd0; nsl[u] = 8'd0;
        abt[u] = 1'b0; dn[u] = 1'b0;
      end else begin
        mstep(u);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d",
               nm, act, exp, edge_n);
    end
  endtask

  task automatic cmp_unit(input int u, input logic [2:0] ph,
                          input logic bz, input logic dd,
                          input logic ab, input logic [7:0] sw,
                          input logic ud, input logic en,
                          input int cnt);
    int eph, ec;
    bit ebz, eud, een;
    string pre;
    pre = (u == 0) ? "a" : "b";
    case (md[u])
      M_RUN: begin
        exp_at(t[u], dw[u], eph, ec);
        ebz = 1'b1;
        eud = (eph <= 2);
        een = (eph == 1 && ec != N-1) || (eph == 3 && ec != 0);
      end
      M_RET: begin
        eph = 5; ec = rc[u] - k[u]; ebz = 1'b1;
        eud = 1'b0; een = (ec != 0);
      end
      default: begin
        eph = 0; ec = 0; ebz = 1'b0; eud = 1'b0; een = 1'b0;
      end
    endcase
    chk({pre, ".phase"}, 32'(ph), eph);
    chk({pre, ".count"}, cnt, ec);
    chk({pre, ".busy"}, 32'(bz), 32'(ebz));
    chk({pre, ".done"}, 32'(dd), 32'(dn[u]));
    chk({pre, ".aborted"}, 32'(ab), 32'(abt[u]));
    chk({pre, ".sweep_cnt"}, 32'(sw), 32'(swc[u]));
    chk({pre, ".up_down"}, 32'(ud), 32'(eud));
    chk({pre, ".cnt_en"}, 32'(en), 32'(een));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_unit(0, ifa.phase, ifa.busy, ifa.done, ifa.aborted,
               ifa.sweep_cnt, ifa.cnt_up_down, ifa.cnt_en, cnt_a);
      cmp_unit(1, ifb.phase, ifb.busy, ifb.done, ifb.aborted,
               ifb.sweep_cnt, ifb.cnt_up_down, ifb.cnt_en, cnt_b);
    end
  end

  function automatic logic done_of(input int u);
    return (u == 0) ? ifa.done : ifb.done;
  endfunction

  task automatic do_start(input int u, input logic [7:0] nsw,
                          output int s);
    @(posedge clk); #1;
    ns_v[u] = nsw;
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    s = edge_n;
    start_v[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int s,
                           input int bound, output int d);
    d = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done_of(u)) begin
        d = edge_n - s;
        break;
      end
    end
  endtask

  task automatic to_edge(input int e);
    for (int g = 0; g < 1000 && edge_n < e; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic abort_at(input int u, input int s, input int e);
    to_edge(s + e - 1);
    abort_v[u] = 1'b1;
    @(posedge clk); #1;
    abort_v[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, d, prev, idx, gap;
    int steps [3];
    bit bad_ph;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b1;
    chk("rst.busy", 32'(ifa.busy), 0);
    chk("rst.phase", 32'(ifa.phase), 0);
    chk("rst.sweep_cnt", 32'(ifa.sweep_cnt), 0);
    chk("rst.count", cnt_a, 0);
    rst = 1'b1;
    idle(2);

    // single sweep
    do_start(0, 8'd1, s);
    wait_done(0, s, 100, d);
    chk("one.done_edge", d, 40);
    chk("one.sweep_cnt", 32'(ifa.sweep_cnt), 1);
    chk("one.aborted", 32'(ifa.aborted), 0);
    idle(3);

    // three sweeps back to back
    do_start(0, 8'd3, s);
    prev = 0; idx = 0; gap = 0; d = -1;
    steps = '{-1, -1, -1};
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (int'(ifa.sweep_cnt) != prev && idx < 3) begin
        steps[idx] = edge_n - s;
        idx++;
        prev = int'(ifa.sweep_cnt);
      end
      if (ifa.done) begin
        d = edge_n - s;
        break;
      end
      if (!ifa.busy) gap++;
    end
    chk("three.done_edge", d, 120);
    chk("three.step1", steps[0], 40);
    chk("three.step2", steps[1], 80);
    chk("three.step3", steps[2], 120);
    chk("three.idle_gap", gap, 0);
    idle(3);

    // continuous run aborted while counting up the second sweep
    do_start(0, 8'd0, s);
    abort_at(0, s, 50);
    wait_done(0, s, 100, d);
    chk("ab50.done_edge", d, 61);
    chk("ab50.aborted", 32'(ifa.aborted), 1);
    chk("ab50.sweep_cnt", 32'(ifa.sweep_cnt), 1);
    idle(3);

    // abort during top dwell
    do_start(0, 8'd0, s);
    abort_at(0, s, 18);
    wait_done(0, s, 100, d);
    chk("ab18.done_edge", d, 34);
    chk("ab18.aborted", 32'(ifa.aborted), 1);
    idle(3);

    // abort in last bottom-dwell cycle beats end of sweep
    do_start(0, 8'd1, s);
    abort_at(0, s, 40);
    wait_done(0, s, 100, d);
    chk("ablast.done_edge", d, 41);
    chk("ablast.sweep_cnt", 32'(ifa.sweep_cnt), 0);
    chk("ablast.aborted", 32'(ifa.aborted), 1);
    idle(3);

    // start with abort in idle is dropped
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    ns_v[0] = 8'd1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("stab.busy", 32'(ifa.busy), 0);
    idle(2);

    // start while busy is ignored
    do_start(0, 8'd1, s);
    to_edge(s + 10);
    start_v[0] = 1'b1;
    ns_v[0] = 8'd5;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, s, 100, d);
    chk("busy_start.done_edge", d, 40);
    idle(3);

    // reset mid-run
    do_start(0, 8'd0, s);
    to_edge(s + 24);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy", 32'(ifa.busy), 0);
    chk("midrst.count", cnt_a, 0);
    chk("midrst.done", 32'(ifa.done), 0);
    @(posedge clk); #1;
    chk("midrst.done2", 32'(ifa.done), 0);
    rst = 1'b1;
    idle(2);
    do_start(0, 8'd1, s);
    wait_done(0, s, 100, d);
    chk("after_rst.done_edge", d, 40);
    idle(3);

    // no dwell build
    do_start(1, 8'd2, s);
    bad_ph = 1'b0;
    d = -1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (ifb.phase == 3'd2 || ifb.phase == 3'd4) bad_ph = 1'b1;
      if (ifb.done) begin
        d = edge_n - s;
        break;
      end
    end
    chk("nodwell.done_edge", d, 64);
    chk("nodwell.dwell_phase_seen", 32'(bad_ph), 0);
    chk("nodwell.sweep_cnt", 32'(ifb.sweep_cnt), 2);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
